// File: rtl/timer_irq_ctrl_pkg.sv
// Shared constants for the timer interrupt collector: register indices and source numbering.
package timer_irq_pkg;

  localparam int NUM_SRC = 2;
  localparam int SRC_OVF = 0;
  localparam int SRC_CMP = 1;

  typedef enum logic [1:0] {
    REG_PENDING  = 2'd0,
    REG_MASK     = 2'd1,
    REG_EVT_CNT  = 2'd2,
    REG_PEND_SET = 2'd3
  } reg_idx_e;

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// APB slave-side signal bundle for the timer interrupt collector.
interface timer_irq_ctrl_if #(
  parameter int APB_ADDR_WIDTH = 12
);
  logic [APB_ADDR_WIDTH-1:0] PADDR;
  logic [31:0]               PWDATA;
  logic                      PWRITE;
  logic                      PSEL;
  logic                      PENABLE;
  logic [31:0]               PRDATA;
  logic                      PREADY;
  logic                      PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/timer_irq_ctrl_src.sv
// One interrupt source: rising-edge detect, sticky pending bit and saturating event counter.
module irq_src_latch #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 irq_in,
  input  logic                 w1c,
  input  logic                 w1s,
  input  logic                 cnt_clr,
  output logic                 pend_next_s,
  output logic                 pend_r,
  output logic [CNT_WIDTH-1:0] cnt_r
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

  logic                 irq_d_r;
  logic                 event_s;
  logic [CNT_WIDTH-1:0] cnt_next_s;

  // Event and pending next-state; hardware set and W1S beat W1C.
  always_comb begin
    event_s     = irq_in & ~irq_d_r;
    pend_next_s = (pend_r & ~w1c) | event_s | w1s;
  end

  // Counter next-state: a clear coinciding with an event leaves a count of one.
  always_comb begin
    cnt_next_s = cnt_r;
    if (cnt_clr) begin
      cnt_next_s = event_s ? CNT_ONE : {CNT_WIDTH{1'b0}};
    end else if (event_s && (cnt_r != CNT_MAX)) begin
      cnt_next_s = cnt_r + CNT_ONE;
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // Source state registers.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      irq_d_r <= 1'b0;
      pend_r  <= 1'b0;
      cnt_r   <= {CNT_WIDTH{1'b0}};
    end else begin
      irq_d_r <= irq_in;
      pend_r  <= pend_next_s;
      cnt_r   <= cnt_next_s;
    end
  end

endmodule

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt collector: APB register window, mask, per-source latches, combined level irq.
module timer_irq_ctrl
  import timer_irq_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int CNT_WIDTH      = 8
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  timer_irq_ctrl_if.slave      apb,
  input  logic [NUM_SRC-1:0]   timer_irq_i,
  output logic                 irq_o
);

  if (APB_ADDR_WIDTH < 4 || CNT_WIDTH < 1 || CNT_WIDTH > 16) begin : g_bad_param
    $error("timer_irq_ctrl: unsupported parameter value");
  end

  reg_idx_e             reg_idx_s;
  logic                 wr_en_s;
  logic                 rd_en_s;
  logic [NUM_SRC-1:0]   w1c_s;
  logic [NUM_SRC-1:0]   w1s_s;
  logic                 cnt_clr_s;
  logic [NUM_SRC-1:0]   mask_next_s;
  logic [NUM_SRC-1:0]   mask_r;
  logic [NUM_SRC-1:0]   pend_next_s;
  logic [NUM_SRC-1:0]   pend_s;
  logic [CNT_WIDTH-1:0] cnt_s [NUM_SRC];
  logic                 irq_r;
  logic [31:0]          prdata_s;

  assign reg_idx_s = reg_idx_e'(apb.PADDR[3:2]);
  assign wr_en_s   = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign rd_en_s   = apb.PSEL & apb.PENABLE & ~apb.PWRITE;

  // Write decode into per-register strobes.
  always_comb begin
    w1c_s       = {NUM_SRC{1'b0}};
    w1s_s       = {NUM_SRC{1'b0}};
    cnt_clr_s   = 1'b0;
    mask_next_s = mask_r;
    if (wr_en_s) begin
      case (reg_idx_s)
        REG_PENDING:  w1c_s       = apb.PWDATA[NUM_SRC-1:0];
        REG_MASK:     mask_next_s = apb.PWDATA[NUM_SRC-1:0];
        REG_EVT_CNT:  cnt_clr_s   = 1'b1;
        REG_PEND_SET: w1s_s       = apb.PWDATA[NUM_SRC-1:0];
        default:      cnt_clr_s   = 1'b0;
      endcase
    end else begin
      mask_next_s = mask_r;
    end
  end

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_src
    irq_src_latch #(
      .CNT_WIDTH (CNT_WIDTH)
    ) u_src (
      .HCLK        (HCLK),
      .HRESETn     (HRESETn),
      .irq_in      (timer_irq_i[k]),
      .w1c         (w1c_s[k]),
      .w1s         (w1s_s[k]),
      .cnt_clr     (cnt_clr_s),
      .pend_next_s (pend_next_s[k]),
      .pend_r      (pend_s[k]),
      .cnt_r       (cnt_s[k])
    );
  end

  // Mask register and irq flop; irq is built from next-state so it tracks pending/mask with no lag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      mask_r <= {NUM_SRC{1'b0}};
      irq_r  <= 1'b0;
    end else begin
      mask_r <= mask_next_s;
      irq_r  <= |(pend_next_s & mask_next_s);
    end
  end

  // Zero-wait read mux; bus reads zero outside a read access phase.
  always_comb begin
    prdata_s = 32'h0000_0000;
    if (rd_en_s) begin
      case (reg_idx_s)
        REG_PENDING:  prdata_s[NUM_SRC-1:0] = pend_s;
        REG_MASK:     prdata_s[NUM_SRC-1:0] = mask_r;
        REG_EVT_CNT: begin
          prdata_s[CNT_WIDTH-1:0]  = cnt_s[SRC_OVF];
          prdata_s[16 +: CNT_WIDTH] = cnt_s[SRC_CMP];
        end
        REG_PEND_SET: prdata_s = 32'h0000_0000;
        default:      prdata_s = 32'h0000_0000;
      endcase
    end else begin
      prdata_s = 32'h0000_0000;
    end
  end

  assign apb.PRDATA  = prdata_s;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;
  assign irq_o       = irq_r;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Self-checking bench for timer_irq_ctrl: vector table, directed corner sequences, random vs. model.
module tb_timer_irq_ctrl;
  import timer_irq_pkg::*;

  localparam int CMAX = 255;

  logic       HCLK = 1'b0;
  logic       HRESETn;
  logic [1:0] timer_irq;
  logic       irq_o;
  int         n_chk  = 0;
  int         n_fail = 0;

  // reference state, kept as plain integers
  int m_pend, m_mask, m_prev, m_irq;
  int m_cnt [2];

  timer_irq_ctrl_if #(.APB_ADDR_WIDTH(12)) bus ();

  timer_irq_ctrl #(.APB_ADDR_WIDTH(12), .CNT_WIDTH(8)) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .apb         (bus),
    .timer_irq_i (timer_irq),
    .irq_o       (irq_o)
  );

  always #5 HCLK = ~HCLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_irq = 0;
    m_cnt[0] = 0; m_cnt[1] = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [1:0] idx);
    case (idx)
      2'd0:    return 32'(m_pend);
      2'd1:    return 32'(m_mask);
      2'd2:    return 32'(m_cnt[0] + m_cnt[1] * 65536);
      default: return 32'h0;
    endcase
  endfunction

  // one clock edge of the register-map rules applied to the reference state
  task automatic model_step(input logic [1:0] irq, input logic wr_commit,
                            input logic [1:0] idx, input logic [31:0] wd);
    int ev, clr, w1c, w1s;
    ev  = int'(irq) & ~m_prev & 3;
    clr = (wr_commit && idx == 2'd2) ? 1 : 0;
    w1c = (wr_commit && idx == 2'd0) ? int'(wd[1:0]) : 0;
    w1s = (wr_commit && idx == 2'd3) ? int'(wd[1:0]) : 0;
    if (wr_commit && idx == 2'd1) m_mask = int'(wd[1:0]);
    m_pend = ((m_pend & ~w1c) | ev | w1s) & 3;
    for (int k = 0; k < 2; k++) begin
      if (clr != 0) m_cnt[k] = (ev >> k) & 1;
      else if (((ev >> k) & 1) != 0) m_cnt[k] = (m_cnt[k] + 1 > CMAX) ? CMAX : m_cnt[k] + 1;
    end
    m_prev = int'(irq);
    m_irq  = ((m_pend & m_mask) != 0) ? 1 : 0;
  endtask

  // drive one cycle from posedge+1, check PRDATA mid-cycle and irq_o after the edge
  task automatic do_cycle(input logic [1:0] irq, input logic sel, input logic en, input logic wr,
                          input logic [1:0] idx, input logic [31:0] wd, output logic [31:0] rd);
    logic [11:0] addr;
    logic [31:0] exp_rd;
    addr = 12'($urandom);
    addr[3:2] = idx;
    bus.PADDR = addr; bus.PSEL = sel; bus.PENABLE = en; bus.PWRITE = wr; bus.PWDATA = wd;
    timer_irq = irq;
    @(negedge HCLK);
    exp_rd = (sel && en && !wr) ? model_read(idx) : 32'h0;
    rd = bus.PRDATA;
    chk("prdata", rd, exp_rd);
    @(posedge HCLK);
    model_step(irq, sel && en && wr, idx, wd);
    #1;
    chk("irq_o", {31'h0, irq_o}, 32'(m_irq));
  endtask

  task automatic idle(input logic [1:0] irq);
    logic [31:0] d;
    do_cycle(irq, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, d);
  endtask

  task automatic apb_wr(input logic [1:0] irq_s, input logic [1:0] irq_a,
                        input logic [1:0] idx, input logic [31:0] wd);
    logic [31:0] d;
    do_cycle(irq_s, 1'b1, 1'b0, 1'b1, idx, wd, d);
    do_cycle(irq_a, 1'b1, 1'b1, 1'b1, idx, wd, d);
  endtask

  task automatic apb_rd(input logic [1:0] irq_s, input logic [1:0] irq_a,
                        input logic [1:0] idx, output logic [31:0] rd);
    logic [31:0] d;
    do_cycle(irq_s, 1'b1, 1'b0, 1'b0, idx, 32'h0, d);
    do_cycle(irq_a, 1'b1, 1'b1, 1'b0, idx, 32'h0, rd);
  endtask

  typedef struct {
    int          op;       // 0 idle, 1 write, 2 read
    logic [1:0]  irq_s;
    logic [1:0]  irq_a;
    logic [1:0]  idx;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [15];

  initial begin
    logic [31:0] rd;
    logic [1:0]  r_irq, r_irq2, r_idx;

    vecs[0]  = '{1, 2'b00, 2'b00, REG_MASK,     32'h3, 32'h0, 1'b0};
    vecs[1]  = '{0, 2'b01, 2'b01, REG_PENDING,  32'h0, 32'h0, 1'b1};
    vecs[2]  = '{0, 2'b00, 2'b00, REG_PENDING,  32'h0, 32'h0, 1'b1};
    vecs[3]  = '{2, 2'b00, 2'b00, REG_PENDING,  32'h0, 32'h1, 1'b1};
    vecs[4]  = '{2, 2'b00, 2'b00, REG_EVT_CNT,  32'h0, 32'h1, 1'b1};
    vecs[5]  = '{1, 2'b00, 2'b00, REG_PENDING,  32'h1, 32'h0, 1'b0};
    vecs[6]  = '{2, 2'b00, 2'b00, REG_PENDING,  32'h0, 32'h0, 1'b0};
    vecs[7]  = '{1, 2'b00, 2'b00, REG_MASK,     32'h1, 32'h0, 1'b0};
    vecs[8]  = '{0, 2'b10, 2'b10, REG_PENDING,  32'h0, 32'h0, 1'b0};
    vecs[9]  = '{0, 2'b00, 2'b00, REG_PENDING,  32'h0, 32'h0, 1'b0};
    vecs[10] = '{2, 2'b00, 2'b00, REG_PENDING,  32'h0, 32'h2, 1'b0};
    vecs[11] = '{1, 2'b00, 2'b00, REG_MASK,     32'h3, 32'h0, 1'b1};
    vecs[12] = '{2, 2'b00, 2'b00, REG_MASK,     32'h0, 32'h3, 1'b1};
    vecs[13] = '{1, 2'b00, 2'b00, REG_EVT_CNT,  32'h0, 32'h0, 1'b1};
    vecs[14] = '{1, 2'b00, 2'b00, REG_PENDING,  32'h2, 32'h0, 1'b0};

    // reset state
    HRESETn = 1'b0; timer_irq = 2'b00;
    bus.PADDR = 12'h0; bus.PWDATA = 32'h0; bus.PWRITE = 1'b0; bus.PSEL = 1'b0; bus.PENABLE = 1'b0;
    model_reset();
    @(posedge HCLK); @(posedge HCLK); #1;
    chk("rst_irq_o",   {31'h0, irq_o},        32'h0);
    chk("rst_prdata",  bus.PRDATA,            32'h0);
    chk("rst_pready",  {31'h0, bus.PREADY},   32'h1);
    chk("rst_pslverr", {31'h0, bus.PSLVERR},  32'h0);
    HRESETn = 1'b1;

    // vector table
    for (int i = 0; i < 15; i++) begin
      case (vecs[i].op)
        0: idle(vecs[i].irq_a);
        1: apb_wr(vecs[i].irq_s, vecs[i].irq_a, vecs[i].idx, vecs[i].wd);
        default: begin
          apb_rd(vecs[i].irq_s, vecs[i].irq_a, vecs[i].idx, rd);
          chk($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
        end
      endcase
      chk($sformatf("vec%0d_irq", i), {31'h0, irq_o}, {31'h0, vecs[i].exp_irq});
    end

    // compare line held high for 10 cycles -> exactly one event
    for (int i = 0; i < 10; i++) idle(2'b10);
    apb_rd(2'b00, 2'b00, REG_EVT_CNT, rd);
    chk("hold_cnt", rd, 32'h0001_0000);
    apb_rd(2'b00, 2'b00, REG_PENDING, rd);
    chk("hold_pend", rd, 32'h2);
    chk("hold_irq", {31'h0, irq_o}, 32'h1);
    apb_wr(2'b00, 2'b00, REG_PENDING, 32'h2);

    // overflow counter saturation, then clear coincident with a new event
    for (int i = 0; i < 300; i++) begin
      idle(2'b01);
      idle(2'b00);
    end
    apb_rd(2'b00, 2'b00, REG_EVT_CNT, rd);
    chk("sat_cnt", rd, 32'h0001_00FF);
    apb_wr(2'b00, 2'b01, REG_EVT_CNT, 32'h0);
    apb_rd(2'b00, 2'b00, REG_EVT_CNT, rd);
    chk("clr_evt_cnt", rd, 32'h0000_0001);

    // W1C loses to a same-cycle event; PEND_SET injection
    apb_wr(2'b00, 2'b00, REG_PENDING, 32'h3);
    idle(2'b01);
    idle(2'b00);
    apb_wr(2'b00, 2'b01, REG_PENDING, 32'h1);
    apb_rd(2'b00, 2'b00, REG_PENDING, rd);
    chk("w1c_vs_evt", rd, 32'h1);
    apb_wr(2'b00, 2'b00, REG_PEND_SET, 32'h2);
    apb_rd(2'b00, 2'b00, REG_PENDING, rd);
    chk("pend_set", rd, 32'h3);
    apb_rd(2'b00, 2'b00, REG_PEND_SET, rd);
    chk("pend_set_rd0", rd, 32'h0);
    apb_wr(2'b00, 2'b00, REG_MASK, 32'h0);
    chk("mask_off_irq", {31'h0, irq_o}, 32'h0);
    apb_wr(2'b00, 2'b00, REG_MASK, 32'h3);
    chk("mask_on_irq", {31'h0, irq_o}, 32'h1);

    // asynchronous reset mid-operation, release with overflow line high
    HRESETn = 1'b0;
    #2;
    chk("async_rst_irq", {31'h0, irq_o}, 32'h0);
    @(posedge HCLK); #1;
    timer_irq = 2'b01;
    HRESETn = 1'b1;
    model_reset();
    apb_rd(2'b01, 2'b01, REG_EVT_CNT, rd);
    chk("post_rst_cnt", rd, 32'h1);
    apb_rd(2'b01, 2'b01, REG_PENDING, rd);
    chk("post_rst_pend", rd, 32'h1);
    apb_rd(2'b01, 2'b01, REG_MASK, rd);
    chk("post_rst_mask", rd, 32'h0);

    // randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      r_irq  = 2'($urandom);
      r_irq2 = 2'($urandom);
      r_idx  = 2'($urandom);
      case ($urandom_range(0, 3))
        0, 1: idle(r_irq);
        2:    apb_wr(r_irq, r_irq2, r_idx, $urandom);
        default: apb_rd(r_irq, r_irq2, r_idx, rd);
      endcase
    end
    chk("end_pready",  {31'h0, bus.PREADY},  32'h1);
    chk("end_pslverr", {31'h0, bus.PSLVERR}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
